// File: rtl/toy_bus_mem_tgt.sv
// Bus memory target: accepts one request at a time, forwards hits to a
// single-port SRAM and always returns an ack so the bus cannot hang.
module toy_bus_mem_tgt #(
  parameter logic [3:0]  NODE_ID = 4'd5,
  parameter int unsigned MEM_AW  = 12
) (
  input  logic              clk,
  input  logic              rst,
  // Request channel
  input  logic              in_req_vld,
  output logic              in_req_rdy,
  input  logic [31:0]       in_req_addr,
  input  logic [31:0]       in_req_data,
  input  logic [3:0]        in_req_strb,
  input  logic              in_req_opcode,
  input  logic [3:0]        in_req_src_id,
  input  logic [3:0]        in_req_tgt_id,
  // Ack channel
  output logic              in_ack_vld,
  input  logic              in_ack_rdy,
  output logic              in_ack_opcode,
  output logic [31:0]       in_ack_data,
  output logic [3:0]        in_ack_src_id,
  output logic [3:0]        in_ack_tgt_id,
  // SRAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StAck    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  src_q;
  logic        op_q;
  logic        hit_q;
  logic [31:0] data_q;

  logic fire;
  logic hit;

  // Byte-offset bits and bits above the SRAM range are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{in_req_addr[31:MEM_AW+2], in_req_addr[1:0]};

  assign hit  = (in_req_tgt_id == NODE_ID);
  // Reset masks the handshake so no SRAM access can leak out while rst is high.
  assign fire = in_req_vld & in_req_rdy & ~rst;

  // Output decode and next-state selection
  always_comb begin
    state_d    = state_q;
    in_req_rdy = 1'b0;
    in_ack_vld = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_req_rdy = 1'b1;
        if (fire) begin
          state_d = (hit && !in_req_opcode) ? StRdWait : StAck;
        end
      end
      StRdWait: state_d = StAck;
      StAck: begin
        in_ack_vld = 1'b1;
        if (in_ack_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM drive comes straight from the request so a read hit returns in N+1
  assign mem_en    = fire & hit;
  assign mem_we    = in_req_opcode;
  assign mem_addr  = in_req_addr[MEM_AW+1:2];
  assign mem_wdata = in_req_data;
  assign mem_wstrb = in_req_strb;

  assign in_ack_opcode = op_q;
  assign in_ack_data   = data_q;
  assign in_ack_src_id = NODE_ID;
  assign in_ack_tgt_id = src_q;

  // State register and latched request context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= 4'h0;
      op_q    <= 1'b0;
      hit_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        src_q  <= in_req_src_id;
        op_q   <= in_req_opcode;
        hit_q  <= hit;
        data_q <= 32'h0;
      end else if (state_q == StRdWait) begin
        data_q <= hit_q ? mem_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_toy_bus_mem_tgt.sv
// Directed bench for toy_bus_mem_tgt with a small byte-strobed SRAM model.
module tb_toy_bus_mem_tgt;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_req_vld;
  logic          in_req_rdy;
  logic [31:0]   in_req_addr;
  logic [31:0]   in_req_data;
  logic [3:0]    in_req_strb;
  logic          in_req_opcode;
  logic [3:0]    in_req_src_id;
  logic [3:0]    in_req_tgt_id;
  logic          in_ack_vld;
  logic          in_ack_rdy;
  logic          in_ack_opcode;
  logic [31:0]   in_ack_data;
  logic [3:0]    in_ack_src_id;
  logic [3:0]    in_ack_tgt_id;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] sram [2**AW];

  always #5 clk = ~clk;

  toy_bus_mem_tgt #(.NODE_ID(4'd5), .MEM_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_req_vld    (in_req_vld),
    .in_req_rdy    (in_req_rdy),
    .in_req_addr   (in_req_addr),
    .in_req_data   (in_req_data),
    .in_req_strb   (in_req_strb),
    .in_req_opcode (in_req_opcode),
    .in_req_src_id (in_req_src_id),
    .in_req_tgt_id (in_req_tgt_id),
    .in_ack_vld    (in_ack_vld),
    .in_ack_rdy    (in_ack_rdy),
    .in_ack_opcode (in_ack_opcode),
    .in_ack_data   (in_ack_data),
    .in_ack_src_id (in_ack_src_id),
    .in_ack_tgt_id (in_ack_tgt_id),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata)
  );

  // SRAM model: byte-strobed write, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] src, input logic [3:0] tgt);
    in_req_vld    = 1'b1;
    in_req_opcode = op;
    in_req_addr   = addr;
    in_req_data   = data;
    in_req_strb   = strb;
    in_req_src_id = src;
    in_req_tgt_id = tgt;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) sram[i] = 32'h0;
    mem_rdata  = 32'h0;
    rst        = 1'b1;
    in_ack_rdy = 1'b1;
    // Valid request during reset must not reach the SRAM
    drive_req(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 4'h1, 4'h5);
    tick();
    check("rst_mem_en", mem_en, 0);
    tick();
    check("rst_mem_en2", mem_en, 0);
    in_req_vld = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_req_rdy", in_req_rdy, 1);
    check("rst_ack_vld", in_ack_vld, 0);
    check("rst_ack_data", in_ack_data, 0);
    check("rst_ack_tgt", in_ack_tgt_id, 0);

    // Write hit
    drive_req(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 4'h1, 4'h5);
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 4);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5_1234);
    check("wr_mem_wstrb", mem_wstrb, 4'hF);
    tick();
    in_req_vld = 1'b0;
    check("wr_ack_vld", in_ack_vld, 1);
    check("wr_ack_op", in_ack_opcode, 1);
    check("wr_ack_data", in_ack_data, 0);
    check("wr_ack_src", in_ack_src_id, 5);
    check("wr_ack_tgt", in_ack_tgt_id, 1);
    check("wr_req_rdy", in_req_rdy, 0);
    tick();
    check("wr_done_rdy", in_req_rdy, 1);
    check("wr_done_vld", in_ack_vld, 0);

    // Read hit of the word just written
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 4'h2, 4'h5);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 4);
    tick();
    in_req_vld = 1'b0;
    check("rd_n1_ack_vld", in_ack_vld, 0);
    check("rd_n1_req_rdy", in_req_rdy, 0);
    check("rd_n1_mem_en", mem_en, 0);
    tick();
    check("rd_ack_vld", in_ack_vld, 1);
    check("rd_ack_data", in_ack_data, 32'hA5A5_1234);
    check("rd_ack_op", in_ack_opcode, 0);
    check("rd_ack_tgt", in_ack_tgt_id, 2);
    tick();
    check("rd_done_rdy", in_req_rdy, 1);

    // Miss with ack backpressure; request-side changes while busy are ignored
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 4'h7, 4'h3);
    check("miss_mem_en", mem_en, 0);
    in_ack_rdy = 1'b0;
    tick();
    drive_req(1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 4'h9, 4'h5);
    check("miss_ack_vld", in_ack_vld, 1);
    check("miss_ack_data", in_ack_data, 0);
    check("miss_ack_tgt", in_ack_tgt_id, 7);
    for (int c = 0; c < 5; c++) begin
      check("bp_ack_vld", in_ack_vld, 1);
      check("bp_ack_tgt", in_ack_tgt_id, 7);
      check("bp_ack_op", in_ack_opcode, 0);
      check("bp_ack_data", in_ack_data, 0);
      check("bp_req_rdy", in_req_rdy, 0);
      check("bp_mem_en", mem_en, 0);
      tick();
    end
    in_req_vld = 1'b0;
    in_ack_rdy = 1'b1;
    #1;
    check("bp_ack_vld_end", in_ack_vld, 1);
    tick();
    check("bp_after_rdy", in_req_rdy, 1);
    check("bp_after_vld", in_ack_vld, 0);

    // Zero-strobe write still accesses and acks
    drive_req(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 4'h3, 4'h5);
    check("wz_mem_en", mem_en, 1);
    check("wz_mem_wstrb", mem_wstrb, 0);
    tick();
    in_req_vld = 1'b0;
    check("wz_ack_vld", in_ack_vld, 1);
    check("wz_ack_op", in_ack_opcode, 1);
    check("wz_ack_tgt", in_ack_tgt_id, 3);
    tick();

    // Reset in RD_WAIT drops the read
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 4'h4, 4'h5);
    tick();
    in_req_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_in_rdwait", in_ack_vld, 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_ack_vld", in_ack_vld, 0);
    check("abort_req_rdy", in_req_rdy, 1);
    check("abort_mem_en", mem_en, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_no_ack", in_ack_vld, 0);
      check("abort_no_mem", mem_en, 0);
    end

    // Address wrap within the SRAM, also confirms zero-strobe write kept data
    drive_req(1'b0, 32'h0000_4004, 32'h0, 4'h0, 4'h6, 4'h5);
    check("wrap_mem_addr", mem_addr, 1);
    check("wrap_mem_en", mem_en, 1);
    tick();
    in_req_vld = 1'b0;
    tick();
    check("wrap_ack_vld", in_ack_vld, 1);
    check("wrap_ack_data", in_ack_data, 0);
    check("wrap_ack_tgt", in_ack_tgt_id, 6);
    tick();
    drive_req(1'b0, 32'hFFFF_C012, 32'h0, 4'h0, 4'h8, 4'h5);
    check("wrap2_mem_addr", mem_addr, 4);
    tick();
    in_req_vld = 1'b0;
    tick();
    check("wrap2_ack_data", in_ack_data, 32'hA5A5_1234);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toy_bus_mem_tgt.md
TOY_BUS_MEM_TGT -- requirements
Module: toy_bus_mem_tgt

Interface
REQ-001 The block SHALL have parameter NODE_ID, default 4'd5, meaning the bus target id this node answers to.
REQ-002 The block SHALL have parameter MEM_AW, default 12, meaning the word-address width of the attached SRAM.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock.
REQ-004 The block SHALL have port rst, input, 1, meaning the reset: synchronous, active-high.
REQ-005 The block SHALL have ports in_req_vld (input, 1) and in_req_rdy (output, 1), meaning the request handshake.
REQ-006 The block SHALL have in_req_addr (input, 32), in_req_data (input, 32), in_req_strb (input, 4), in_req_opcode (input, 1; 0=read, 1=write), in_req_src_id (input, 4) and in_req_tgt_id (input, 4), meaning the request payload.
REQ-007 The block SHALL have ports in_ack_vld (output, 1) and in_ack_rdy (input, 1), meaning the ack handshake.
REQ-008 The block SHALL have in_ack_opcode (output, 1), in_ack_data (output, 32), in_ack_src_id (output, 4) and in_ack_tgt_id (output, 4), meaning the ack payload.
REQ-009 The block SHALL have SRAM ports: mem_en (output, 1), mem_we (output, 1), mem_addr (output, MEM_AW), mem_wdata (output, 32), mem_wstrb (output, 4), mem_rdata (input, 32; valid the cycle after mem_en with mem_we=0).

Function
REQ-010 The block SHALL implement FSM states IDLE, RD_WAIT, ACK.
REQ-011 IDLE: in_req_rdy SHALL be 1 and in_ack_vld 0; in every other state, in_req_rdy SHALL be 0.
REQ-012 Request fire (vld&rdy) SHALL latch in_req_src_id, in_req_opcode and hit = (in_req_tgt_id == NODE_ID).
REQ-013 mem_en SHALL be combinational = fire & hit; mem_we = in_req_opcode; mem_addr = in_req_addr[MEM_AW+1:2]; mem_wdata/mem_wstrb = in_req_data/in_req_strb.
REQ-014 Transitions: IDLE->RD_WAIT on fire of a read hit; IDLE->ACK on fire of a write or a miss; RD_WAIT->ACK unconditionally (capturing mem_rdata into the ack data register); ACK->IDLE on in_ack_rdy.
REQ-015 Latency SHALL be: write/miss fire in cycle N -> in_ack_vld in N+1; read-hit fire in cycle N -> in_ack_vld in N+2.
REQ-016 In ACK, in_ack_vld SHALL be 1 and the payload SHALL be held stable until in_ack_rdy; backpressure of any length SHALL be allowed.
REQ-017 Ack payload SHALL be: in_ack_opcode = latched opcode; in_ack_src_id = NODE_ID; in_ack_tgt_id = latched src_id.
REQ-018 in_ack_data SHALL be the captured mem_rdata for a read hit, and 32'h0 for a write or a miss.
REQ-019 Miss (tgt_id != NODE_ID): mem_en SHALL stay 0, and the request SHALL still be acked, so the bus never hangs.
REQ-020 Address bits [1:0] and bits above MEM_AW+1 SHALL be ignored (wrap within the SRAM).
REQ-021 A write with strb=4'b0000 SHALL still pulse mem_en and SHALL be acked normally.
REQ-022 At most one request SHALL be outstanding; a new request SHALL NOT be accepted in the cycle the ack fires (IDLE is re-entered the next cycle).
REQ-023 Input payload SHALL be sampled only in the fire cycle; changes while in_req_rdy=0 SHALL be ignored.

Reset
REQ-024 rst=1 at a clock edge SHALL force state to IDLE, clear the latched src_id/opcode/hit/data registers to 0, and leave outputs in_ack_vld=0, in_req_rdy=1, mem_en=0.
REQ-025 Reset mid-transaction (RD_WAIT or ACK) SHALL drop the pending ack without issuing it; no further SRAM access SHALL occur for that request.
REQ-026 During rst=1, mem_en SHALL be 0 regardless of in_req_vld.

Verification
REQ-027 Write hit: addr=0x0000_0010, data=0xA5A5_1234, strb=4'hF, src_id=1, tgt_id=5 -> same cycle mem_en=1, mem_we=1, mem_addr=4; next cycle ack_vld=1, opcode=1, data=0, src_id=5, tgt_id=1.
REQ-028 Read hit after that write (SRAM model returns 0xA5A5_1234) -> mem_en=1, mem_we=0 in N; ack_vld in N+2 with data=0xA5A5_1234, opcode=0.
REQ-029 Miss: tgt_id=3, read -> mem_en stays 0; ack in N+1 with data=0, tgt_id=req src_id.
REQ-030 Backpressure: in_ack_rdy held 0 for 5 cycles in ACK -> ack_vld and payload stable, in_req_rdy=0 throughout; in_req_rdy=1 the cycle after ack fires.
REQ-031 Reset in RD_WAIT -> next cycle in_ack_vld=0, in_req_rdy=1, and no ack is ever produced for the aborted read.
REQ-032 Address wrap: read at addr=0x0000_4004 with MEM_AW=12 -> mem_addr=1.
